// File: rtl/addsub64_sequencer_pkg.sv
// Shared types and constants for the 64-bit add/sub sequencer and its 32-bit datapath.
package addsub64_sequencer_pkg;
  localparam int HALF_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/addsub64_sequencer_addsub32_cin.sv
// 32-bit adder/subtractor with explicit carry-in and carry-out (sub inverts b; caller supplies cin).
module addsub32_cin
  import addsub64_sequencer_pkg::*;
(
  input  logic [HALF_W-1:0] a_i,
  input  logic [HALF_W-1:0] b_i,
  input  logic              sub_i,
  input  logic              cin_i,
  output logic [HALF_W-1:0] sum_o,
  output logic              cout_o
);
  logic [HALF_W-1:0] b_eff;
  logic [HALF_W:0]   full;

  assign b_eff  = sub_i ? ~b_i : b_i;
  assign full   = {1'b0, a_i} + {1'b0, b_eff} + {{HALF_W{1'b0}}, cin_i};
  assign sum_o  = full[HALF_W-1:0];
  assign cout_o = full[HALF_W];
endmodule

// File: rtl/addsub64_sequencer.sv
// Sequencer that time-shares one 32-bit add/sub datapath over one (ALU32) or two (ALU64) passes.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; valid is never retracted before that edge.
module addsub64_sequencer
  import addsub64_sequencer_pkg::*;
#(
  parameter bit CARRY_AS_BORROW = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op_sub,
  input  logic        op_64,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        carry,
  output logic        busy,
  output state_e      state_dbg
);
  state_e            state_q, state_d;
  logic [63:0]       a_q, b_q;
  logic              op_sub_q, op_64_q;
  logic              carry_lo_q;
  logic [63:0]       result_q;
  logic              carry_q;

  logic [HALF_W-1:0] half_a, half_b, half_sum;
  logic              half_cin, half_cout;
  logic              cout_fixed;

  // HI pass works on the upper halves and chains the low-pass carry; otherwise the low pass.
  always_comb begin
    half_a   = a_q[HALF_W-1:0];
    half_b   = b_q[HALF_W-1:0];
    half_cin = op_sub_q;
    if (state_q == HI) begin
      half_a   = a_q[63:HALF_W];
      half_b   = b_q[63:HALF_W];
      half_cin = carry_lo_q;
    end
  end

  addsub32_cin u_addsub (
    .a_i    (half_a),
    .b_i    (half_b),
    .sub_i  (op_sub_q),
    .cin_i  (half_cin),
    .sum_o  (half_sum),
    .cout_o (half_cout)
  );

  assign cout_fixed = half_cout ^ (CARRY_AS_BORROW & op_sub_q);

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = LO;
      end
      LO:   state_d = op_64_q ? HI : DONE;
      HI:   state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_sub_q   <= 1'b0;
      op_64_q    <= 1'b0;
      carry_lo_q <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          a_q      <= a;
          b_q      <= b;
          op_sub_q <= op_sub;
          op_64_q  <= op_64;
        end
        LO: begin
          // Upper half cleared here so ALU32 results come out zero-extended.
          result_q   <= {{HALF_W{1'b0}}, half_sum};
          carry_lo_q <= half_cout;
          if (!op_64_q) carry_q <= cout_fixed;
        end
        HI: begin
          result_q[63:HALF_W] <= half_sum;
          carry_q             <= cout_fixed;
        end
        default: ;
      endcase
    end
  end

  assign result    = result_q;
  assign carry     = carry_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_addsub64_sequencer.sv
// Self-checking bench: randomized and directed requests against an arithmetic reference model.
module tb_addsub64_sequencer;
  import addsub64_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, op_sub, op_64, out_ready;
  logic [63:0] a, b;
  logic        in_ready0, out_valid0, carry0, busy0;
  logic        in_ready1, out_valid1, carry1, busy1;
  logic [63:0] result0, result1;
  state_e      dbg0, dbg1;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [64:0] exp_q[$];
  logic [64:0] exp1_q[$];

  always #5 clk = ~clk;

  addsub64_sequencer #(.CARRY_AS_BORROW(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .op_sub(op_sub), .op_64(op_64), .a(a), .b(b),
    .out_valid(out_valid0), .out_ready(out_ready), .result(result0),
    .carry(carry0), .busy(busy0), .state_dbg(dbg0)
  );

  addsub64_sequencer #(.CARRY_AS_BORROW(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .op_sub(op_sub), .op_64(op_64), .a(a), .b(b),
    .out_valid(out_valid1), .out_ready(out_ready), .result(result1),
    .carry(carry1), .busy(busy1), .state_dbg(dbg1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {carry, result} from plain integer arithmetic on the chosen width.
  function automatic logic [64:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic sub, input logic w64, input logic cab);
    logic [63:0] v;
    logic        c;
    logic [31:0] x32, y32;
    logic [32:0] s33;
    if (w64) begin
      if (sub) begin
        v = x - y;
        c = (x >= y);
      end else begin
        {c, v} = {1'b0, x} + {1'b0, y};
      end
    end else begin
      x32 = x[31:0];
      y32 = y[31:0];
      if (sub) begin
        v = {32'b0, x32 - y32};
        c = (x32 >= y32);
      end else begin
        s33 = {1'b0, x32} + {1'b0, y32};
        v   = {32'b0, s33[31:0]};
        c   = s33[32];
      end
    end
    if (cab && sub) c = ~c;
    return {c, v};
  endfunction

  task automatic run_req(input logic [63:0] ra, input logic [63:0] rb,
                         input logic rsub, input logic r64, input int hold);
    logic [64:0] e0, e1;
    int          lat;
    @(negedge clk);
    a = ra; b = rb; op_sub = rsub; op_64 = r64; in_valid = 1'b1; out_ready = 1'b0;
    check("in_ready_idle", 64'(in_ready0), 64'd1);
    exp_q.push_back(model(ra, rb, rsub, r64, 1'b0));
    exp1_q.push_back(model(ra, rb, rsub, r64, 1'b1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    op_sub = ~rsub;
    op_64  = ~r64;
    lat = 1;
    while (!out_valid0 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), r64 ? 64'd3 : 64'd2);
    e0 = exp_q.pop_front();
    e1 = exp1_q.pop_front();
    check("result", result0, e0[63:0]);
    check("carry", 64'(carry0), 64'(e0[64]));
    check("result_borrow_mode", result1, e1[63:0]);
    check("carry_borrow_mode", 64'(carry1), 64'(e1[64]));
    check("busy_done", 64'(busy0), 64'd1);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      @(negedge clk);
      check("hold_result", result0, e0[63:0]);
      check("hold_carry", 64'(carry0), 64'(e0[64]));
      check("hold_out_valid", 64'(out_valid0), 64'd1);
      check("hold_in_ready", 64'(in_ready0), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("after_handshake_state", 64'(dbg0), 64'(IDLE));
    check("after_handshake_out_valid", 64'(out_valid0), 64'd0);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ta, tb_op;
    logic [63:0] edge_vals [4];
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_sub = 1'b0; op_64 = 1'b0;
    a = '0; b = '0;
    edge_vals[0] = 64'h0;
    edge_vals[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    edge_vals[2] = 64'h0000_0000_FFFF_FFFF;
    edge_vals[3] = 64'h8000_0000_0000_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_state", 64'(dbg0), 64'(IDLE));
    check("reset_in_ready", 64'(in_ready0), 64'd1);
    check("reset_out_valid", 64'(out_valid0), 64'd0);
    check("reset_busy", 64'(busy0), 64'd0);
    check("reset_result", result0, 64'd0);
    check("reset_carry", 64'(carry0), 64'd0);

    run_req(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0);
    run_req(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 0);
    run_req(64'h0000_0001_0000_0000, 64'd1, 1'b1, 1'b1, 0);
    run_req(64'hDEAD_0000_0000_0005, 64'hBEEF_0000_0000_0003, 1'b1, 1'b0, 0);
    run_req(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1, 5);

    // Abandon an ALU64 operation while in the high pass.
    @(negedge clk);
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; op_sub = 1'b0; op_64 = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pre_reset_state_hi", 64'(dbg0), 64'(HI));
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("mid_reset_state", 64'(dbg0), 64'(IDLE));
    check("mid_reset_out_valid", 64'(out_valid0), 64'd0);
    check("mid_reset_result", result0, 64'd0);
    check("mid_reset_carry", 64'(carry0), 64'd0);
    run_req(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 1);

    for (int n = 0; n < 40; n++) begin
      ta    = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : {$urandom, $urandom};
      tb_op = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : {$urandom, $urandom};
      run_req(ta, tb_op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
